// File: rtl/fir_out_quant.sv
// rtl/fir_out_quant.sv - FIR output rounding/quantization with FWFT output FIFO and drop counter
// Optional: define FIR_OUT_QUANT_SAT_EN to saturate to the output range instead of wrapping.
module fir_out_quant #(
    parameter int IN_INTE_WL  = 4,
    parameter int IN_FRAC_WL  = 8,
    parameter int OUT_INTE_WL = 4,
    parameter int OUT_FRAC_WL = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IN_INTE_WL+IN_FRAC_WL-1:0]   data_in,
    input  logic                               in_valid,
    input  logic [7:0]                         frac_wl,
    output logic [OUT_INTE_WL+OUT_FRAC_WL-1:0] data_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [7:0]                         drop_cnt,
    input  logic                               drop_clr
);
    localparam int IW = IN_INTE_WL + IN_FRAC_WL;
    localparam int OW = OUT_INTE_WL + OUT_FRAC_WL;
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef FIR_OUT_QUANT_SAT_EN
    // One guard bit so the rounding carry is visible to the saturation check.
    localparam int RW = IW + 1;
`else
    // Wrapping only needs the output width; higher bits never reach data_out.
    localparam int RW = OW;
`endif

    logic [7:0]    k;
    logic [7:0]    shift;
    logic [RW-1:0] src;
    logic [RW-1:0] one;
    logic [RW-1:0] half;
    logic [RW-1:0] mask;
    logic [RW-1:0] rounded;
    logic [OW-1:0] q;

    always_comb begin
        k       = (frac_wl > 8'(IN_FRAC_WL)) ? 8'(IN_FRAC_WL) : frac_wl;
        shift   = 8'(IN_FRAC_WL) - k;
        one     = {{(RW-1){1'b0}}, 1'b1};
        half    = (shift == 8'd0) ? '0 : (one << (shift - 8'd1));
        mask    = ~((one << shift) - one);
`ifdef FIR_OUT_QUANT_SAT_EN
        src     = {data_in[IW-1], data_in};
        rounded = (src + half) & mask;
        if ((rounded[RW-1:OW-1] == '0) || (rounded[RW-1:OW-1] == '1))
            q = rounded[OW-1:0];
        else if (rounded[RW-1])
            q = {1'b1, {(OW-1){1'b0}}};
        else
            q = {1'b0, {(OW-1){1'b1}}};
`else
        src     = data_in[OW-1:0];
        rounded = (src + half) & mask;
        q       = rounded;
`endif
    end

    logic          s1_valid;
    logic [OW-1:0] s1_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_data  <= q;
        end
    end

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [OW-1:0] mem [FIFO_DEPTH];
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = s1_valid && (!full || pop);
    assign drop  = s1_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= s1_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= 8'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (drop_clr)
                drop_cnt <= 8'd0;
            else if (drop && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign out_valid = !empty;
    assign data_out  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: doc/fir_out_quant.md
FIR_OUT_QUANT -- requirements
Module: fir_out_quant

Interface
REQ-001 SHALL have parameter IN_INTE_WL, default 4, integer bits of the input sample.
REQ-002 SHALL have parameter IN_FRAC_WL, default 8, fraction bits of the input sample; must equal OUT_FRAC_WL.
REQ-003 SHALL have parameter OUT_INTE_WL, default 4, integer bits of the output; must be at most IN_INTE_WL.
REQ-004 SHALL have parameter OUT_FRAC_WL, default 8, fraction bits of the output.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries; power of two, at least 2.
REQ-006 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port data_in  input  IN_INTE_WL+IN_FRAC_WL  signed FIR output sample.
REQ-009 SHALL have port in_valid  input  1  data_in is valid this cycle; there is no backpressure upstream.
REQ-010 SHALL have port frac_wl  input  8  number of fraction bits kept after rounding.
REQ-011 SHALL have port data_out  output  OUT_INTE_WL+OUT_FRAC_WL  signed head-of-FIFO sample.
REQ-012 SHALL have port out_valid  output  1  FIFO is not empty.
REQ-013 SHALL have port out_ready  input  1  consumer accepts data_out.
REQ-014 SHALL have port drop_cnt  output  8  saturating count of dropped samples.
REQ-015 SHALL have port drop_clr  input  1  synchronous clear of drop_cnt.

Function
REQ-016 SHALL clamp the effective kept bits k to min(frac_wl, IN_FRAC_WL), sampled in the same cycle as in_valid.
REQ-017 SHALL round half-up when k<IN_FRAC_WL: add 2^(IN_FRAC_WL-k-1) raw LSBs in a one-guard-bit-wider word, then zero the low IN_FRAC_WL-k bits.
REQ-018 SHALL pass data_in unchanged when k=IN_FRAC_WL.
REQ-019 SHALL register the rounded result and its valid in stage 1; a push into the FIFO occurs on the next edge.
REQ-020 SHALL give a latency of 2 clk edges from in_valid to out_valid when the FIFO is empty.
REQ-021 SHALL use a first-word-fall-through FIFO: data_out shows the head entry whenever out_valid=1.
REQ-022 SHALL pop on the edge where out_valid=1 and out_ready=1, and shall keep data_out stable while out_valid=1 and out_ready=0.
REQ-023 SHALL accept a simultaneous push and pop when the FIFO is full, leaving the occupancy unchanged.
REQ-024 SHALL ignore a pop request when the FIFO is empty; a push into an empty FIFO is not visible until the following cycle.
REQ-025 SHALL drop the stage-1 sample, leaving FIFO contents unchanged, when the FIFO is full and no pop occurs in that cycle.
REQ-026 SHALL increment drop_cnt on each drop and hold it at 255.
REQ-027 SHALL give drop_clr priority over an increment in the same cycle, so drop_cnt becomes 0.
REQ-028 SHALL wrap the read and write pointers modulo FIFO_DEPTH and distinguish full from empty with an extra pointer bit.

Reset
REQ-029 SHALL, while rst=0, asynchronously clear the stage-1 valid, both pointers and drop_cnt, so that out_valid=0, data_out=0 and drop_cnt=0.
REQ-030 SHALL discard all buffered samples on reset asserted mid-stream.
REQ-031 SHALL produce no phantom output after reset release; the first out_valid follows the first post-reset in_valid by 2 edges.

Configuration
REQ-032 SHALL, with macro FIR_OUT_QUANT_SAT_EN defined, saturate the rounded value to the OUT format range: max 2^(OUT_INTE_WL+OUT_FRAC_WL-1)-1, min -2^(OUT_INTE_WL+OUT_FRAC_WL-1).
REQ-033 SHALL, without FIR_OUT_QUANT_SAT_EN, take the low OUT_INTE_WL+OUT_FRAC_WL bits of the rounded value (two's-complement wrap).

Verification
REQ-034 SHALL cover rounding at defaults, out_ready=1, frac_wl=4: raw 24 -> 32; raw 23 -> 16; raw -24 -> -16; each with out_valid 2 edges after in_valid.
REQ-035 SHALL cover overflow: raw 0x7FF, frac_wl=0 -> 0x7FF with FIR_OUT_QUANT_SAT_EN, 0x800 without it.
REQ-036 SHALL cover backpressure: out_ready=0, 6 consecutive in_valid -> 4 stored, drop_cnt=2; then out_ready=1 -> the first 4 samples come out in order.
REQ-037 SHALL cover a full FIFO with simultaneous push and pop -> no drop, occupancy stays 4, order preserved.
REQ-038 SHALL cover saturation and clear: 300 drops -> drop_cnt=255; drop_clr with a concurrent drop -> drop_cnt=0.
REQ-039 SHALL cover reset: rst low with 3 entries buffered -> out_valid=0 and drop_cnt=0 immediately; after release, no output until a new in_valid.
